// File: rtl/mnd_ctrl_pkg.sv
// Shared MND operation/write-enable codes and decode helpers for the E-stage
// multiply/divide sequencer.
package mnd_ctrl_pkg;

   localparam logic [3:0] MNDMULT  = 4'd1;
   localparam logic [3:0] MNDMULTU = 4'd2;
   localparam logic [3:0] MNDDIV   = 4'd3;
   localparam logic [3:0] MNDDIVU  = 4'd4;

   localparam logic [1:0] MNDNOWRITE = 2'd0;
   localparam logic [1:0] MNDWRITEHI = 2'd1;
   localparam logic [1:0] MNDWRITELO = 2'd2;

   typedef enum logic {StIdle, StRun} mnd_state_e;

   function automatic logic is_valid_op(input logic [3:0] t);
      return (t == MNDMULT) || (t == MNDMULTU) || (t == MNDDIV) || (t == MNDDIVU);
   endfunction

   function automatic logic is_mult_op(input logic [3:0] t);
      return (t == MNDMULT) || (t == MNDMULTU);
   endfunction

endpackage

// File: rtl/mnd_arith.sv
// Combinational multiply/divide datapath: produces the pending HI/LO pair,
// including the divide-by-zero and signed-overflow results.
module mnd_arith
   import mnd_ctrl_pkg::*;
(
   input  logic [3:0]  Type,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] pend_hi,
   output logic [31:0] pend_lo
);

   logic        sgn;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic [31:0] quo;
   logic [31:0] rem;

   // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   always_comb begin
      sgn    = (Type == MNDDIV);
      prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      prod_u = {32'b0, A} * {32'b0, B};
      dvd    = (sgn && A[31]) ? -A : A;
      dvs    = (sgn && B[31]) ? -B : B;
      quo    = (dvs == '0) ? '0 : dvd / dvs;
      rem    = (dvs == '0) ? '0 : dvd % dvs;
   end

   always_comb begin
      pend_hi = '0;
      pend_lo = '0;
      case (Type)
         MNDMULT: begin
            pend_hi = prod_s[63:32];
            pend_lo = prod_s[31:0];
         end
         MNDMULTU: begin
            pend_hi = prod_u[63:32];
            pend_lo = prod_u[31:0];
         end
         MNDDIV, MNDDIVU: begin
            if (B == '0) begin
               pend_hi = A;
               pend_lo = 32'hFFFF_FFFF;
            end else begin
               pend_lo = (sgn && (A[31] ^ B[31])) ? -quo : quo;
               pend_hi = (sgn && A[31]) ? -rem : rem;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mnd_ctrl.sv
// E-stage multiply/divide sequencer: busy countdown, HI/LO ownership and the
// D-stage stall request.
module mnd_ctrl
   import mnd_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  Type,
   input  logic [1:0]  WE,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        requestInt,
   input  logic        DUsesMND,
   output logic        Busy,
   output logic        Stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

   mnd_state_e        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       hi_q, hi_d, lo_q, lo_d;
   logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic [31:0]       arith_hi, arith_lo;
   logic              accept;

   mnd_arith u_arith (
      .Type    (Type),
      .A       (A),
      .B       (B),
      .pend_hi (arith_hi),
      .pend_lo (arith_lo)
   );

   assign Busy   = (state_q == StRun);
   assign accept = Start & ~requestInt & ~Busy & is_valid_op(Type);
   assign Stall  = DUsesMND & (Busy | accept);
   assign HI     = hi_q;
   assign LO     = lo_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               pend_hi_d = arith_hi;
               pend_lo_d = arith_lo;
               cnt_d     = is_mult_op(Type) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
               state_d   = StRun;
            end else if (!Start && !requestInt) begin
               // Start outranks a move-to in the same cycle.
               if (WE == MNDWRITEHI) hi_d = A;
               if (WE == MNDWRITELO) lo_d = A;
            end
         end
         StRun: begin
            if (cnt_q == CntW'(1)) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

endmodule

// File: tb/tb_mnd_ctrl.sv
// Self-checking bench for mnd_ctrl: directed scenarios plus randomized traffic
// against a cycle-count/longint-arithmetic reference model.
module tb_mnd_ctrl;
   import mnd_ctrl_pkg::*;

   localparam int MultN = 5;
   localparam int DivN  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic [3:0]  Type = '0;
   logic [1:0]  WE = MNDNOWRITE;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        requestInt = 1'b0;
   logic        DUsesMND = 1'b0;
   logic        Busy;
   logic        Stall;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
   int          m_left = 0;

   mnd_ctrl #(
      .MULT_CYCLES (MultN),
      .DIV_CYCLES  (DivN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .Start      (Start),
      .Type       (Type),
      .WE         (WE),
      .A          (A),
      .B          (B),
      .requestInt (requestInt),
      .DUsesMND   (DUsesMND),
      .Busy       (Busy),
      .Stall      (Stall),
      .HI         (HI),
      .LO         (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic ref_valid(input logic [3:0] t);
      case (t)
         MNDMULT, MNDMULTU, MNDDIV, MNDDIVU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Returns {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_op(input logic [3:0] t, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if ((t == MNDDIV || t == MNDDIVU) && b == 0) return {a, 32'hFFFF_FFFF};
      case (t)
         MNDMULT:  p = sa * sb;
         MNDMULTU: p = ua * ub;
         MNDDIV: begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
         end
         default: begin
            uq = ua / ub;
            ur = ua % ub;
            p  = {ur[31:0], uq[31:0]};
         end
      endcase
      return p;
   endfunction

   task automatic step(input logic s, input logic [3:0] t, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] b, input logic ri,
                       input logic du, input logic rst);
      logic        acc;
      logic [63:0] r;
      @(negedge clk);
      Start = s; Type = t; WE = w; A = a; B = b;
      requestInt = ri; DUsesMND = du; reset = rst;
      #1;
      acc = s && !ri && (m_left == 0) && ref_valid(t);
      chk("stall", {31'b0, Stall}, {31'b0, du && (acc || m_left > 0)});
      if (s) chk("start_while_busy", {31'b0, Busy}, 32'd0);
      @(posedge clk);
      if (rst) begin
         m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (acc) begin
         r      = ref_op(t, a, b);
         m_phi  = r[63:32];
         m_plo  = r[31:0];
         m_left = (t == MNDMULT || t == MNDMULTU) ? MultN : DivN;
      end else if (!s && !ri) begin
         if (w == MNDWRITEHI) m_hi = a;
         if (w == MNDWRITELO) m_lo = a;
      end
      #1;
      chk("busy", {31'b0, Busy}, {31'b0, m_left > 0});
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
   endtask

   task automatic idle(input int n, input logic du);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, MNDNOWRITE, $urandom, $urandom, 1'b0, du, 1'b0);
   endtask

   task automatic op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                     input logic du);
      step(1'b1, t, MNDNOWRITE, a, b, 1'b0, du, 1'b0);
   endtask

   initial begin
      int          busy_cnt;
      logic [3:0]  rt;
      logic [31:0] ra, rb;
      logic [1:0]  rw;

      step(1'b0, 4'd0, MNDNOWRITE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'd0, MNDNOWRITE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("reset_busy", {31'b0, Busy}, 32'd0);
      chk("reset_hi", HI, 32'd0);

      // mult -3 * 7, count busy cycles explicitly
      op(MNDMULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < 8 && Busy; i++) begin
         busy_cnt++;
         idle(1, 1'b0);
      end
      chk("mult_busy_len", busy_cnt, MultN);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFEB);

      // divu with DUsesMND held; model checks Stall every cycle including the one after
      op(MNDDIVU, 32'd100, 32'd7, 1'b1);
      idle(DivN, 1'b1);
      chk("divu_lo", LO, 32'd14);
      chk("divu_hi", HI, 32'd2);

      op(MNDDIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(DivN, 1'b0);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      chk("div_hi", HI, 32'hFFFF_FFFF);

      op(MNDDIV, 32'd5, 32'd0, 1'b0);
      idle(DivN, 1'b0);
      chk("div0_lo", LO, 32'hFFFF_FFFF);
      chk("div0_hi", HI, 32'd5);

      op(MNDDIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(DivN, 1'b0);
      chk("ovf_lo", LO, 32'h8000_0000);
      chk("ovf_hi", HI, 32'd0);

      // requestInt squashes accept and move-to
      step(1'b1, MNDMULT, MNDNOWRITE, 32'd2, 32'd3, 1'b1, 1'b1, 1'b0);
      chk("ri_busy", {31'b0, Busy}, 32'd0);
      step(1'b0, 4'd0, MNDWRITEHI, 32'h1234, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("ri_mthi", HI, 32'd0);

      // requestInt while in flight does not cancel
      op(MNDMULT, 32'd6, 32'hFFFF_FFFC, 1'b0);
      step(1'b0, 4'd0, MNDNOWRITE, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      idle(MultN - 1, 1'b0);
      chk("inflight_hi", HI, 32'hFFFF_FFFF);
      chk("inflight_lo", LO, 32'hFFFF_FFE8);

      // reset in cycle 3 of a div discards the result
      op(MNDDIV, 32'd1000, 32'd3, 1'b0);
      idle(1, 1'b0);
      step(1'b0, 4'd0, MNDNOWRITE, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_busy", {31'b0, Busy}, 32'd0);
      idle(DivN + 2, 1'b0);
      chk("rst_mid_lo", LO, 32'd0);

      step(1'b0, 4'd0, MNDWRITELO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("mtlo", LO, 32'hDEAD_BEEF);
      step(1'b0, 4'd0, MNDWRITEHI, 32'h55, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("mthi", HI, 32'h55);
      chk("mthi_busy", {31'b0, Busy}, 32'd0);

      // Randomized traffic; stimulus respects the hazard-unit guarantees
      for (int i = 0; i < 600; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(1, 9);
            default: ;
         endcase
         case ($urandom_range(0, 5))
            0: rt = MNDMULT;
            1: rt = MNDMULTU;
            2: rt = MNDDIV;
            3: rt = MNDDIVU;
            4: rt = 4'd7;
            default: rt = 4'd0;
         endcase
         rw = 2'($urandom_range(0, 2));
         if (m_left > 0) begin
            step(1'b0, rt, MNDNOWRITE, ra, rb, ($urandom_range(0, 7) == 0),
                 1'($urandom), ($urandom_range(0, 99) == 0));
         end else if ($urandom_range(0, 1) == 0) begin
            step(1'b1, rt, MNDNOWRITE, ra, rb, ($urandom_range(0, 7) == 0),
                 1'($urandom), ($urandom_range(0, 99) == 0));
         end else begin
            step(1'b0, rt, rw, ra, rb, ($urandom_range(0, 7) == 0),
                 1'($urandom), ($urandom_range(0, 99) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mnd_ctrl.md
Name: mnd_ctrl

Overview:
- Multiply/divide sequencer for the E stage. Consumes the MND control fields held in the D/E pipeline register: start, operation type and HI/LO write enables.
- Runs a multi-cycle busy countdown, owns the HI/LO registers and exports the stall request that the hazard unit ORs into Froze.
- Squashes new operations when an interrupt or exception is requested.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Start  input  1  E-stage MNDStartOut; begin operation this cycle
- Type  input  4  E-stage MNDTypeOut: MNDMULT, MNDMULTU, MNDDIV, MNDDIVU (others = no-op)
- WE  input  2  E-stage MNDWEOut: MNDNOWRITE, MNDWRITEHI, MNDWRITELO
- A  input  32  forwarded rs operand (E stage)
- B  input  32  forwarded rt operand (E stage)
- requestInt  input  1  exception/interrupt taken this cycle; squash E-stage MND action
- DUsesMND  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- Busy  output  1  operation in progress
- Stall  output  1  request to freeze D (ORed into Froze)
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset values: Busy=0, HI=0, LO=0, internal counter=0, pending result=0. Stall is combinational and therefore 0 whenever Busy=0 and Start=0.
- Accept rule: an operation is accepted when Start=1, requestInt=0, Busy=0 and Type is a valid op. If Start=1 while Busy=1, it is ignored; the hazard unit guarantees this cannot occur, and the bench asserts it never does.
- On accept:
  - Compute the result from A and B, sampled in that cycle, into pending HI/LO.
  - Load the counter with N = MULT_CYCLES or DIV_CYCLES.
  - Busy rises on the next edge.
- Countdown: the counter decrements once per cycle while Busy=1. In the cycle where counter==1, the next edge writes pending→HI/LO, clears Busy and zeroes the counter.
- Busy timing: Busy is high for exactly N cycles. HI/LO take the new value N edges after the accept edge.
- Arithmetic:
  - mult: signed 32x32→64, HI=upper 32 bits, LO=lower 32 bits.
  - multu: unsigned 32x32→64, same split.
  - div: signed; LO=quotient, HI=remainder, truncating toward zero, remainder takes the sign of the dividend.
  - divu: unsigned; same assignment.
- Divide by zero (B==0): LO=32'hFFFF_FFFF, HI=A. No exception is raised.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- mthi/mtlo: when WE≠MNDNOWRITE, requestInt=0 and Busy=0, the next edge writes A into HI or LO. When Busy=1 the write is ignored (the hazard unit stalls, so this cannot occur).
- Simultaneous WE and Start in the same cycle: illegal, since it cannot be decoded from one instruction. Start has priority.
- requestInt:
  - Blocks accept and mthi/mtlo in the same cycle.
  - An operation already in flight (Busy=1) completes normally and commits to HI/LO, per MIPS semantics.
- Stall = DUsesMND & (Busy | accepted-this-cycle). This is combinational and holds D until the cycle after Busy falls.
- Reset mid-operation: Busy is cleared, the counter is cleared, HI=LO=0 and the pending result is discarded.
- No state machine is needed beyond IDLE (Busy=0) and RUN (Busy=1). The counter width is clog2(max(MULT_CYCLES, DIV_CYCLES))+1.

Decomposition:
- MNDTYPE*, MNDWRITE* and MNDNOWRITE codes live in the shared paras.v include, next to the existing MND defaults.
- One combinational sub-module, mnd_arith, takes (Type, A, B) and returns {pendHI, pendLO}, including the div-by-zero and overflow rules. mnd_ctrl holds the counter, Busy and the HI/LO registers.

Test Plan:
- Reset, then mult A=-3, B=7: Busy high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB on the 5th edge after accept.
- divu A=100, B=7: Busy for 10 cycles, then LO=14, HI=2. Hold DUsesMND=1 throughout: Stall=1 from the accept cycle through the last Busy cycle, and 0 in the following cycle.
- div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div A=5, B=0 → LO=0xFFFFFFFF, HI=5.
- Start=1 with requestInt=1 (mult 2*3): Busy stays 0 and HI/LO are unchanged. Then mthi with A=0x1234 and requestInt=1: HI is unchanged.
- mult in flight, requestInt pulsed in cycle 2: the operation still completes with the correct HI/LO. reset asserted in cycle 3 of a div: the next edge gives Busy=0, HI=LO=0, and no later commit occurs.
- mtlo A=0xDEADBEEF at idle → LO=0xDEADBEEF after 1 edge. mthi A=0x55 → HI=0x55, and Busy never rises.
